// File: rtl/dff_pipeline_if.sv
// Handshake bundle for dff_pipeline: upstream valid/ready/data, downstream
// valid/ready/data, flush control and occupancy status.
interface dff_pipeline_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             flush;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output in_valid, d, out_ready, flush,
    input  in_ready, out_valid, q, occupancy
  );

  modport slave (
    input  in_valid, d, out_ready, flush,
    output in_ready, out_valid, q, occupancy
  );
endinterface

// File: rtl/dff_pipeline.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit data with per-stage valid,
// valid/ready on both ends, bubble collapsing, synchronous flush and occupancy.
module dff_pipeline #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  dff_pipeline_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data     [DEPTH];
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] src_vld;
  logic [DEPTH-1:0] adv;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // A stage may load when it is empty or when every stage downstream of it moves.
  always_comb begin
    logic room;
    room = bus.out_ready;
    adv  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      room   = room | ~vld[i];
      adv[i] = room;
    end
  end

  assign bus.in_ready = rst_n & ~bus.flush & adv[0];
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = vld[DEPTH-1] & bus.out_ready & ~bus.flush;

  always_comb begin
    src_vld     = '0;
    src_vld[0]  = push;
    src_data[0] = bus.d;
    for (int i = 1; i < DEPTH; i++) begin
      src_vld[i]  = vld[i-1];
      src_data[i] = data[i-1];
    end
  end

  // Data only moves with a valid word so an emptied output keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
    end else if (bus.flush) begin
      vld   <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          vld[i] <= src_vld[i];
          if (src_vld[i]) data[i] <= src_data[i];
        end
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  assign bus.out_valid = vld[DEPTH-1];
  assign bus.q         = data[DEPTH-1];
  assign bus.occupancy = count;
endmodule

// File: tb/tb_dff_pipeline.sv
// Randomised and directed bench for dff_pipeline with a queue-based reference
// model: accepted words are queued, the output monitor pops and compares.
module tb_dff_pipeline;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   lat_exact = 1'b0;
  ent_t sb[$];

  dff_pipeline_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dff_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] v);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.d        = v;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_ready && t < 200);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word 0x%0h not accepted within 200 cycles", v);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Reference model: FIFO of accepted words; in_ready follows from model fill level.
  always @(negedge clk) begin
    logic exp_rdy;
    ent_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      exp_rdy = !bus.flush && (bus.out_ready || sb.size() < DEPTH);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("occupancy", 32'(bus.occupancy), 32'(sb.size()));
      if (bus.out_valid && sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: out_valid with q=0x%0h, expected no valid word", bus.q);
      end else if (bus.out_valid) begin
        chk("q_order", 32'(bus.q), 32'(sb[0].data));
        if (bus.out_ready && !bus.flush) begin
          if (lat_exact) chk("latency", 32'(cyc - sb[0].cyc), 32'(DEPTH));
          else           chk("latency_min", 32'((cyc - sb[0].cyc) >= DEPTH), 32'd1);
          void'(sb.pop_front());
        end
      end
      if (bus.flush) begin
        sb.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        e.data = bus.d;
        e.cyc  = cyc;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.d         = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset observed before any clock edge
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_q", 32'(bus.q), 32'h00);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Streaming at full rate with exact latency
    bus.out_ready = 1'b1;
    lat_exact = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(8'(k));
      if (k == 4) chk("stream_occupancy", 32'(bus.occupancy), 32'd4);
    end
    step(DEPTH + 2);
    lat_exact = 1'b0;
    chk("stream_drained", 32'(bus.occupancy), 32'd0);

    // Back-pressure: only DEPTH words fit
    bus.out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(8'hA0 + 8'(k));
      end
    join_none
    step(8);
    chk("bp_occupancy", 32'(bus.occupancy), 32'd4);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_q_head", 32'(bus.q), 32'hA0);
    bus.out_ready = 1'b1;
    wait fork;
    step(8);
    chk("bp_drained", 32'(bus.occupancy), 32'd0);

    // Bubbles collapse toward the output
    bus.out_ready = 1'b0;
    send(8'h11);
    step(2);
    send(8'h22);
    step(6);
    chk("bub_occupancy", 32'(bus.occupancy), 32'd2);
    chk("bub_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bub_q", 32'(bus.q), 32'h11);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bub_drain0", 32'({bus.out_valid, bus.q}), 32'h111);
    @(negedge clk);
    chk("bub_drain1", 32'({bus.out_valid, bus.q}), 32'h122);
    step(3);

    // Full push and pop in the same cycle
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(8'h40 + 8'(k));
    step(2);
    chk("full_occupancy", 32'(bus.occupancy), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    send(8'h55);
    chk("full_pushpop", 32'(bus.occupancy), 32'd4);
    step(8);
    chk("full_drained", 32'(bus.occupancy), 32'd0);

    // Flush drops the contents and the simultaneous input word
    bus.out_ready = 1'b0;
    send(8'h31);
    send(8'h32);
    send(8'h33);
    chk("fl_occupancy", 32'(bus.occupancy), 32'd3);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.d        = 8'hFF;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_occupancy_after", 32'(bus.occupancy), 32'd0);
    chk("fl_out_valid_after", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    send(8'h5A);
    step(8);
    chk("fl_recovered", 32'(bus.occupancy), 32'd0);

    // Random traffic with occasional flush
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.d         = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 63) == 0);
      step(1);
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    step(DEPTH + 4);
    chk("rand_drained", 32'(bus.occupancy), 32'd0);

    // Asynchronous reset in the middle of traffic
    bus.out_ready = 1'b0;
    send(8'h77);
    send(8'h78);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_q", 32'(bus.q), 32'h00);
    chk("mrst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("mrst_in_ready_after", 32'(bus.in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
